// File: rtl/dcache_assoc_wb.sv
// N-way set-associative, write-back, write-allocate data cache.
// CPU side: a request is held while p1_stall_o is high and is taken on the
// first clock edge where p1_stall_o is low. Memory side: mem_enable_o together
// with mem_addr_o/mem_write_o/mem_data_o stays stable until mem_ack_i pulses
// for one cycle. A pulse outside WRITEBACK/READMISS is ignored.
module dcache_assoc_wb #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WAY_W  = AGE_W;
  localparam int WORD_W = OFF_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_READMISS,
    S_READMISSOK
  } state_t;

  state_t state_q;

  // Storage: control bits are reset, tags and line data are not.
  logic [TAG_W-1:0]       tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]      data_q  [SETS][WAYS];
  logic [WAYS-1:0]        valid_q [SETS];
  logic [WAYS-1:0]        dirty_q [SETS];
  logic [WAYS*AGE_W-1:0]  age_q   [SETS];

  // Miss context, captured when the miss is first seen.
  logic [IDX_W-1:0] miss_idx_q;
  logic [TAG_W-1:0] miss_tag_q;
  logic [WAY_W-1:0] vict_q;

  logic              req;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic [WAYS-1:0]   match;
  logic [WAY_W-1:0]  hit_way;
  logic              hit;
  logic              acc_en;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] merged_line;
  logic [WAY_W-1:0]  vict_way;
  logic              addr_unused;

  assign req      = p1_MemRead_i | p1_MemWrite_i;
  assign req_tag  = p1_addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign req_idx  = p1_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign req_word = p1_addr_i[OFF_W-1:2];
  assign addr_unused = ^p1_addr_i[1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
      if (match[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit        = req & (|match);
  assign p1_stall_o = req & ~hit;
  // Hits are only acted on where the FSM is ready to accept a request;
  // READMISSOK is the replay cycle of a completed miss.
  assign acc_en     = hit && ((state_q == S_IDLE) || (state_q == S_READMISSOK));
  assign hit_line   = data_q[req_idx][hit_way];
  assign p1_data_o  = hit ? 32'(hit_line >> {req_word, 5'd0}) : 32'd0;

  // Store data merged into the hit line; other words pass through.
  always_comb begin
    merged_line = hit_line;
    merged_line[{req_word, 5'd0} +: 32] = p1_data_i;
  end

  // Victim: lowest invalid way, else the oldest way of the set.
  always_comb begin
    logic found;
    vict_way = '0;
    found    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[req_idx][w]) begin
        vict_way = WAY_W'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[req_idx][w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) vict_way = WAY_W'(w);
      end
    end
  end

  // LRU ages: the accessed way becomes 0 and valid ways younger than it age by
  // one. Ages form a permutation over the valid ways; an invalid way being
  // filled counts as the oldest, so every valid way ages on a fill into it.
  function automatic logic [WAYS*AGE_W-1:0] lru_next(
    input logic [WAYS*AGE_W-1:0] ages,
    input logic [WAYS-1:0]       valid,
    input logic [WAY_W-1:0]      way
  );
    logic [AGE_W-1:0]      old_age;
    logic [WAYS*AGE_W-1:0] res;
    old_age = valid[way] ? ages[way*AGE_W +: AGE_W] : AGE_W'(WAYS - 1);
    res = ages;
    for (int v = 0; v < WAYS; v++) begin
      if (WAY_W'(v) == way)
        res[v*AGE_W +: AGE_W] = '0;
      else if (valid[v] && (ages[v*AGE_W +: AGE_W] < old_age))
        res[v*AGE_W +: AGE_W] = ages[v*AGE_W +: AGE_W] + AGE_W'(1);
    end
    return res;
  endfunction

  // Control FSM, control bits, counters and registered memory request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        age_q[s]   <= '0;
      end
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
      vict_q       <= '0;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      if (acc_en) begin
        age_q[req_idx] <= lru_next(age_q[req_idx], valid_q[req_idx], hit_way);
        if (p1_MemWrite_i) dirty_q[req_idx][hit_way] <= 1'b1;
        if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (req && !hit) begin
            state_q    <= S_MISS;
            miss_idx_q <= req_idx;
            miss_tag_q <= req_tag;
            vict_q     <= vict_way;
            if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
          end
        end
        S_MISS: begin
          mem_enable_o <= 1'b1;
          if (valid_q[miss_idx_q][vict_q] && dirty_q[miss_idx_q][vict_q]) begin
            state_q     <= S_WRITEBACK;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {tag_q[miss_idx_q][vict_q], miss_idx_q, {OFF_W{1'b0}}};
            mem_data_o  <= data_q[miss_idx_q][vict_q];
          end else begin
            state_q     <= S_READMISS;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            state_q                     <= S_READMISS;
            dirty_q[miss_idx_q][vict_q] <= 1'b0;
            mem_write_o                 <= 1'b0;
            mem_addr_o                  <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
          end
        end
        S_READMISS: begin
          if (mem_ack_i) begin
            state_q                     <= S_READMISSOK;
            valid_q[miss_idx_q][vict_q] <= 1'b1;
            dirty_q[miss_idx_q][vict_q] <= 1'b0;
            age_q[miss_idx_q]           <= lru_next(age_q[miss_idx_q], valid_q[miss_idx_q], vict_q);
            mem_enable_o                <= 1'b0;
            mem_write_o                 <= 1'b0;
          end
        end
        S_READMISSOK: state_q <= S_IDLE;
        default:      state_q <= S_IDLE;
      endcase
    end
  end

  // Line data and tags: store merges on hits, line fill on read completion.
  always_ff @(posedge clk_i) begin
    if (acc_en && p1_MemWrite_i) data_q[req_idx][hit_way] <= merged_line;
    if ((state_q == S_READMISS) && mem_ack_i) begin
      data_q[miss_idx_q][vict_q] <= mem_data_i;
      tag_q[miss_idx_q][vict_q]  <= miss_tag_q;
    end
  end

endmodule
